// File: rtl/hpdc_mem_rsp_upsizer.sv
// -----------------------------------------------------------------------------
// hpdc_mem_rsp_upsizer
//
// Read-response beat collector on the HPDcache memory side. Narrow read beats
// from the memory interconnect are packed RATIO = OUT_W/IN_W at a time into one
// wide word. The word is presented on the mem_resp_r channel of the miss
// handler. Beat k of a word lands in bits [k*IN_W +: IN_W]. A burst that ends
// early (in_last_i before the top lane) completes a word with its unfilled
// lanes driven to zero.
//
// Build option (macro HPDC_RSP_UPSIZER_PIPE_EN):
//   undefined : single output register with a FILL/HOLD state machine.
//               One wide word takes RATIO+1 cycles.
//   defined   : 2-entry output FIFO. The fill buffer keeps collecting while
//               words wait, so one wide word takes RATIO cycles.
//   Output ordering and field meaning are the same in both builds.
//
// Ports
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   in_valid_i / in_ready_o  narrow beat handshake
//   in_data_i  [IN_W]        beat data
//   in_id_i    [TID_W]       transaction ID, constant within a burst
//   in_error_i, in_last_i    beat bus error, final beat of the burst
//   out_valid_o/out_ready_i  wide word handshake (mem_resp_r)
//   out_data_o [OUT_W]       packed word
//   out_id_o   [TID_W]       ID captured on lane 0
//   out_error_o              OR of in_error_i over the beats of the word
//   out_last_o               in_last_i of the completing beat
// -----------------------------------------------------------------------------
module hpdc_mem_rsp_upsizer #(
  parameter int OUT_W = 512,
  parameter int IN_W  = 128,
  parameter int TID_W = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [IN_W-1:0]  in_data_i,
  input  logic [TID_W-1:0] in_id_i,
  input  logic             in_error_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [OUT_W-1:0] out_data_o,
  output logic [TID_W-1:0] out_id_o,
  output logic             out_error_o,
  output logic             out_last_o
);

  localparam int RATIO = OUT_W / IN_W;
  localparam int CNT_W = $clog2(RATIO);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATIO - 1);

  // ---------------------------------------------------------------------------
  // Fill side: lane counter, lane buffer, ID and error accumulation
  // ---------------------------------------------------------------------------
  logic                       in_ready_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [RATIO-1:0][IN_W-1:0] fill_q;
  logic [TID_W-1:0]           id_q;
  logic                       err_q;

  logic                       beat_acc;
  logic                       word_done;
  logic [OUT_W-1:0]           word_data;
  logic [TID_W-1:0]           word_id;
  logic                       word_err;

  assign in_ready_o = in_ready_q;
  assign beat_acc   = in_valid_i && in_ready_q;
  assign word_done  = beat_acc && (in_last_i || (cnt_q == LAST_LANE));
  // The completing beat may itself be lane 0 (one-beat burst), so its ID is
  // taken directly in that case.
  assign word_id    = (cnt_q == '0) ? in_id_i : id_q;
  assign word_err   = err_q || in_error_i;

  // Assemble the word as it will look once the current beat is added: lanes
  // below cnt come from the buffer, lane cnt from the bus, lanes above are 0.
  // This zero-fills short bursts without ever clearing the buffer.
  always_comb begin
    // NOTE: default assignment first so no path leaves word_data unassigned,
    // which would otherwise infer a latch.
    word_data = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (k < int'(cnt_q)) begin
        word_data[k*IN_W +: IN_W] = fill_q[k];
      end else if (k == int'(cnt_q)) begin
        word_data[k*IN_W +: IN_W] = in_data_i;
      end
    end
  end

  // NOTE: the lane buffer has no reset. A lane is always written before the
  // word mux reads it, and lanes above the count are masked to 0, so reset
  // would only add fan-out on a wide datapath.
  always_ff @(posedge clk_i) begin
    if (beat_acc) begin
      fill_q[cnt_q] <= in_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      cnt_q <= '0;
      id_q  <= '0;
      err_q <= 1'b0;
    end else if (beat_acc) begin
      cnt_q <= word_done ? '0 : cnt_q + 1'b1;
      err_q <= word_done ? 1'b0 : word_err;
      if (cnt_q == '0) begin
        id_q <= in_id_i;
      end
    end
  end

`ifdef HPDC_RSP_UPSIZER_PIPE_EN
  // ---------------------------------------------------------------------------
  // Output side: 2-entry FIFO, head entry drives out_*
  // ---------------------------------------------------------------------------
  logic [1:0]       q_cnt_q;
  logic [1:0]       q_cnt_d;
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [OUT_W-1:0] q_data_q [2];
  logic [TID_W-1:0] q_id_q   [2];
  logic             q_err_q  [2];
  logic             q_last_q [2];
  logic             pop;

  assign pop = (q_cnt_q != 2'd0) && out_ready_i;

  always_comb begin
    q_cnt_d = q_cnt_q;
    if (word_done && !pop) begin
      q_cnt_d = q_cnt_q + 2'd1;
    end else if (!word_done && pop) begin
      q_cnt_d = q_cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      q_cnt_q    <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      in_ready_q <= 1'b1;
      // Entries are cleared because the head entry is the output port itself.
      for (int i = 0; i < 2; i++) begin
        q_data_q[i] <= '0;
        q_id_q[i]   <= '0;
        q_err_q[i]  <= 1'b0;
        q_last_q[i] <= 1'b0;
      end
    end else begin
      // A push never meets a full queue: in_ready_q is low while full.
      if (word_done) begin
        q_data_q[wr_ptr_q] <= word_data;
        q_id_q[wr_ptr_q]   <= word_id;
        q_err_q[wr_ptr_q]  <= word_err;
        q_last_q[wr_ptr_q] <= in_last_i;
        wr_ptr_q           <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      q_cnt_q    <= q_cnt_d;
      in_ready_q <= (q_cnt_d != 2'd2);
    end
  end

  assign out_valid_o = (q_cnt_q != 2'd0);
  assign out_data_o  = q_data_q[rd_ptr_q];
  assign out_id_o    = q_id_q[rd_ptr_q];
  assign out_error_o = q_err_q[rd_ptr_q];
  assign out_last_o  = q_last_q[rd_ptr_q];
`else
  // ---------------------------------------------------------------------------
  // Output side: single register, FILL collects, HOLD presents the word
  // ---------------------------------------------------------------------------
  typedef enum logic {FILL, HOLD} state_e;

  state_e           state_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] out_data_q;
  logic [TID_W-1:0] out_id_q;
  logic             out_error_q;
  logic             out_last_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= FILL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_error_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (word_done) begin
            state_q     <= HOLD;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
            out_data_q  <= word_data;
            out_id_q    <= word_id;
            out_error_q <= word_err;
            out_last_q  <= in_last_i;
          end
        end
        HOLD: begin
          if (out_ready_i) begin
            state_q     <= FILL;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_id_o    = out_id_q;
  assign out_error_o = out_error_q;
  assign out_last_o  = out_last_q;
`endif

`ifndef SYNTHESIS
  // Inside a word the ID must not move; the lane-0 ID is what gets reported.
  id_stable_a: assert property (@(posedge clk_i) disable iff (!rstn_i)
    (beat_acc && (cnt_q != '0)) |-> (in_id_i == id_q))
    else $error("hpdc_mem_rsp_upsizer: in_id_i changed inside a word");
`endif

endmodule

// File: tb/tb_hpdc_mem_rsp_upsizer.sv
// -----------------------------------------------------------------------------
// tb_hpdc_mem_rsp_upsizer
//
// Directed bench for hpdc_mem_rsp_upsizer at default parameters (RATIO = 4).
// A word-level model turns every accepted beat into expected wide words; one
// monitor on the falling edge checks each output handshake against the model,
// checks that stalled outputs hold still, and checks reset values. Directed
// tests add literal expectations and cycle-count checks.
// -----------------------------------------------------------------------------
module tb_hpdc_mem_rsp_upsizer;

  localparam int OUT_W = 512;
  localparam int IN_W  = 128;
  localparam int TID_W = 8;
  localparam int RATIO = OUT_W / IN_W;

`ifdef HPDC_RSP_UPSIZER_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  localparam logic [IN_W-1:0] T1_D0 = 128'h0000_0000_1111_1111_2222_2222_3333_3333;
  localparam logic [IN_W-1:0] T1_D1 = 128'h4444_4444_5555_5555_6666_6666_7777_7777;
  localparam logic [IN_W-1:0] T1_D2 = 128'h8888_8888_9999_9999_AAAA_AAAA_BBBB_BBBB;
  localparam logic [IN_W-1:0] T1_D3 = 128'hCCCC_CCCC_DDDD_DDDD_EEEE_EEEE_FFFF_FFFF;
  localparam logic [IN_W-1:0] T3_D0 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [IN_W-1:0] T3_D1 = 128'hDEAD_BEEF_CAFE_F00D_0BAD_C0DE_1357_9BDF;

  logic             clk;
  logic             rstn;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [TID_W-1:0] in_id;
  logic             in_error;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [TID_W-1:0] out_id;
  logic             out_error;
  logic             out_last;

  hpdc_mem_rsp_upsizer #(.OUT_W(OUT_W), .IN_W(IN_W), .TID_W(TID_W)) dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .in_id_i     (in_id),
    .in_error_i  (in_error),
    .in_last_i   (in_last),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_id_o    (out_id),
    .out_error_o (out_error),
    .out_last_o  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_w(input string name, input logic [OUT_W-1:0] act,
                         input logic [OUT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [IN_W-1:0] beat_data(input int tag, input int k);
    return {32'(tag), 32'(k), 32'hC0DE_0000 + 32'(k), 32'h1234_5678 ^ 32'(tag)};
  endfunction

  // ---------------------------------------------------------------------------
  // Word-level model and monitor
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [OUT_W-1:0] data;
    logic [TID_W-1:0] id;
    logic             err;
    logic             last;
  } word_t;

  word_t            exp_q[$];
  int               beat_cyc_q[$];
  int               pop_cyc_q[$];
  logic [IN_W-1:0]  m_lanes [RATIO];
  int               m_lane = 0;
  logic [TID_W-1:0] m_id = '0;
  logic             m_err = 1'b0;

  logic [OUT_W-1:0] got_data = '0;
  logic [TID_W-1:0] got_id = '0;
  logic             got_err = 1'b0;
  logic             got_last = 1'b0;

  logic             stalled = 1'b0;
  logic [OUT_W-1:0] hold_data = '0;
  logic [TID_W-1:0] hold_id = '0;
  logic             hold_err = 1'b0;
  logic             hold_last = 1'b0;

  always @(negedge clk) begin
    if (!rstn) begin
      check("reset_ctl", 32'({out_valid, out_id, out_error, out_last, in_ready}), 32'h1);
      check_w("reset_data", out_data, '0);
      exp_q.delete();
      m_lane  = 0;
      m_err   = 1'b0;
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check_w("hold_data", out_data, hold_data);
        check("hold_ctl", 32'({out_valid, out_id, out_error, out_last}),
              32'({1'b1, hold_id, hold_err, hold_last}));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word_queue_depth", 32'(exp_q.size()), 32'd1);
        end else begin
          word_t e;
          e = exp_q.pop_front();
          check_w("word_data", out_data, e.data);
          check("word_ctl", 32'({out_id, out_error, out_last}), 32'({e.id, e.err, e.last}));
        end
        got_data = out_data;
        got_id   = out_id;
        got_err  = out_error;
        got_last = out_last;
        pop_cyc_q.push_back(cyc);
      end
      stalled   = out_valid && !out_ready;
      hold_data = out_data;
      hold_id   = out_id;
      hold_err  = out_error;
      hold_last = out_last;
      if (in_valid && in_ready) begin
        beat_cyc_q.push_back(cyc);
        m_lanes[m_lane] = in_data;
        if (m_lane == 0) m_id = in_id;
        m_err  = m_err | in_error;
        m_lane = m_lane + 1;
        if (m_lane == RATIO || in_last) begin
          word_t w;
          w.data = '0;
          for (int k = 0; k < m_lane; k++) w.data[k*IN_W +: IN_W] = m_lanes[k];
          w.id   = m_id;
          w.err  = m_err;
          w.last = in_last;
          exp_q.push_back(w);
          m_lane = 0;
          m_err  = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  task automatic send_beat(input logic [IN_W-1:0] d, input logic [TID_W-1:0] id,
                           input logic err, input logic last);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_id    = id;
    in_error = err;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("beat_accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_error = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_burst(input int n, input logic [TID_W-1:0] id, input int tag,
                            input int err_idx);
    for (int k = 0; k < n; k++) begin
      send_beat(beat_data(tag, k), id, k == err_idx, k == n - 1);
    end
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(posedge clk);
      w++;
    end
    check("drain_pending_words", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed tests
  // ---------------------------------------------------------------------------
  initial begin
    int b0;
    int p0;
    rstn      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_id     = '0;
    in_error  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 1: single full word, latency one cycle after the completing beat
    b0 = beat_cyc_q.size();
    p0 = pop_cyc_q.size();
    send_beat(T1_D0, 8'h2A, 1'b0, 1'b0);
    send_beat(T1_D1, 8'h2A, 1'b0, 1'b0);
    send_beat(T1_D2, 8'h2A, 1'b0, 1'b0);
    send_beat(T1_D3, 8'h2A, 1'b0, 1'b1);
    wait_drain();
    check_w("t1_data", got_data, {T1_D3, T1_D2, T1_D1, T1_D0});
    check("t1_ctl", 32'({got_id, got_err, got_last}), 32'({8'h2A, 1'b0, 1'b1}));
    check("t1_latency", 32'(pop_cyc_q[p0] - beat_cyc_q[b0 + 3]), 32'd1);

    // 2: 8-beat burst, two words, throughput
    b0 = beat_cyc_q.size();
    p0 = pop_cyc_q.size();
    send_burst(8, 8'h05, 2, -1);
    wait_drain();
    check("t2_words", 32'(pop_cyc_q.size() - p0), 32'd2);
    check("t2_span_cycles", 32'(pop_cyc_q[p0 + 1] - beat_cyc_q[b0] + 1), PIPE ? 32'd9 : 32'd10);
    check("t2_last_last", 32'(got_last), 32'd1);

    // 3: short burst zero-fills, next burst starts back in lane 0
    send_beat(T3_D0, 8'h07, 1'b0, 1'b0);
    send_beat(T3_D1, 8'h07, 1'b0, 1'b1);
    wait_drain();
    check_w("t3_data", got_data, {256'h0, T3_D1, T3_D0});
    check("t3_ctl", 32'({got_id, got_err, got_last}), 32'({8'h07, 1'b0, 1'b1}));
    send_burst(4, 8'h08, 3, -1);
    wait_drain();
    check_w("t3_next_data", got_data,
            {beat_data(3, 3), beat_data(3, 2), beat_data(3, 1), beat_data(3, 0)});

    // 4: error on one beat flags only its own word
    send_burst(4, 8'h09, 4, 2);
    wait_drain();
    check("t4_err_word", 32'(got_err), 32'd1);
    send_burst(4, 8'h0A, 5, -1);
    wait_drain();
    check("t4_clean_word", 32'(got_err), 32'd0);

    // 5: output stalled for 20 cycles with 8 beats offered
    b0 = beat_cyc_q.size();
    p0 = pop_cyc_q.size();
    out_ready = 1'b0;
    fork
      send_burst(8, 8'h33, 7, -1);
      begin
        repeat (20) @(posedge clk);
        #1;
        check("t5_beats_taken", 32'(beat_cyc_q.size() - b0), PIPE ? 32'd8 : 32'd4);
        check("t5_in_ready_low", 32'(in_ready), 32'd0);
        check("t5_no_pops", 32'(pop_cyc_q.size() - p0), 32'd0);
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check("t5_words", 32'(pop_cyc_q.size() - p0), 32'd2);

    // 6: reset mid-burst discards the partial word
    p0 = pop_cyc_q.size();
    send_beat(beat_data(9, 0), 8'h44, 1'b0, 1'b0);
    send_beat(beat_data(9, 1), 8'h44, 1'b0, 1'b0);
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    send_burst(4, 8'h11, 6, -1);
    wait_drain();
    check("t6_words", 32'(pop_cyc_q.size() - p0), 32'd1);
    check_w("t6_data", got_data,
            {beat_data(6, 3), beat_data(6, 2), beat_data(6, 1), beat_data(6, 0)});
    check("t6_id", 32'(got_id), 32'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
